// File: rtl/spi_target_regs.sv
// SPI mode-0 target with an 8 x 8-bit register file, a local read port and a write-notify strobe.
// All SPI pins are synchronised into clk; sclk must run at clk/8 or slower.
module spi_target_regs #(
    parameter int SYNC_STAGES = 2,
    parameter int STATUS_ADDR = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] status_in,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       wr_strobe,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data
);
    localparam logic [2:0] STATUS_A = 3'(STATUS_ADDR);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_n_sync, mosi_sync;
    logic                   sclk_s, cs_n_s, mosi_s, sclk_prev;
    logic                   sclk_rise, sclk_fall;

    state_t     state;
    logic       armed;
    logic       is_read;
    logic [2:0] bit_cnt;
    logic [2:0] addr;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] regs [8];

    logic [7:0] rx_next;
    logic [2:0] load_addr;
    logic [7:0] load_data;

    // cs_n resets to "selected" so a frame already under way at reset cannot arm the FSM;
    // only a genuine high level seen afterwards does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_n_sync <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_n_s    = cs_n_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    // NOTE: every signal here is assigned on every path, so no latch can be inferred.
    always_comb begin
        rx_next   = {rx_shift[6:0], mosi_s};
        load_addr = (state == CMD) ? rx_next[2:0] : 3'(addr + 3'd1);
        load_data = (load_addr == STATUS_A) ? status_in : regs[load_addr];
        rd_data   = (rd_addr == STATUS_A) ? status_in : regs[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file is reset explicitly because its contents are visible after reset.
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
            state       <= IDLE;
            armed       <= 1'b0;
            is_read     <= 1'b0;
            bit_cnt     <= 3'd0;
            addr        <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= 3'd0;
            wr_data     <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments everywhere, so every branch reads pre-edge state.
            wr_strobe <= 1'b0;
            if (cs_n_s) begin
                armed       <= 1'b1;
                state       <= IDLE;
                bit_cnt     <= 3'd0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (armed) begin
                            state       <= CMD;
                            spi_miso    <= 1'b0;
                            spi_miso_oe <= 1'b1;
                        end
                    end
                    default: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= 3'(bit_cnt + 3'd1);
                            if (bit_cnt == 3'd7) begin
                                // Byte boundary: the next read byte is captured now, not when shifted.
                                tx_shift <= load_data;
                                if (state == CMD) begin
                                    state   <= DATA;
                                    is_read <= rx_next[7];
                                    addr    <= rx_next[2:0];
                                end else begin
                                    if (!is_read && addr != STATUS_A) begin
                                        regs[addr] <= rx_next;
                                        wr_strobe  <= 1'b1;
                                        wr_addr    <= addr;
                                        wr_data    <= rx_next;
                                    end
                                    addr <= 3'(addr + 3'd1);
                                end
                            end
                        end else if (sclk_fall && state == DATA && is_read) begin
                            spi_miso <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                endcase
            end
        end
    end

endmodule
